capture_sequencer: RTL and testbench

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

---
 rtl/capture_sequencer.sv | 151 +++++++++++++++
 tb/tb_capture_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Two-key capture sequencer: key0 arms, key2 captures the switch value, and an
// armed window that expires without a capture is counted as a timeout.
module capture_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic        clk100_i,
  input  logic        rstn_i,
  input  logic        clr_i,
  input  logic        key0_pressed_i,
  input  logic        key2_pressed_i,
  input  logic [9:0]  sw_i,
  output logic [9:0]  data_o,
  output logic [15:0] count_o,
  output logic [7:0]  err_cnt_o,
  output logic [1:0]  state_o,
  output logic        load_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  localparam logic [26:0] TIMER_LAST = 27'(TIMEOUT_CYCLES - 32'd1);

  state_e      state_q, state_d;
  logic [26:0] timer_q, timer_d;
  logic        key0_prev_q, key0_prev_d;
  logic        key2_prev_q, key2_prev_d;
  logic [9:0]  data_q, data_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  err_q, err_d;
  logic        load_q, load_d;
  logic        timeout_q, timeout_d;

  logic        key0_rise_s;
  logic        key2_rise_s;
  logic        arm_ok_s;
  logic        capture_ok_s;

  assign key0_rise_s  = key0_pressed_i & ~key0_prev_q;
  assign key2_rise_s  = key2_pressed_i & ~key2_prev_q;
  // A rise only counts when the other key is not held at the same time.
  assign arm_ok_s     = key0_rise_s & ~key2_pressed_i;
  assign capture_ok_s = key2_rise_s & ~key0_pressed_i;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    data_d      = data_q;
    count_d     = count_q;
    err_d       = err_q;
    load_d      = 1'b0;
    key0_prev_d = key0_pressed_i;
    key2_prev_d = key2_pressed_i;

    if (clr_i) begin
      state_d = IDLE;
      timer_d = 27'd0;
      data_d  = 10'd0;
      count_d = 16'd0;
      err_d   = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm_ok_s) begin
            state_d = ARMED;
            timer_d = 27'd0;
          end else begin
            state_d = IDLE;
          end
        end
        ARMED: begin
          timer_d = timer_q + 27'd1;
          // Capture beats both re-arm and timeout when they coincide.
          if (capture_ok_s) begin
            state_d = CAPTURE;
          end else if (key0_rise_s) begin
            timer_d = 27'd0;
          end else if (timer_q == TIMER_LAST) begin
            state_d = TIMEOUT;
            if (err_q != 8'hFF) begin
              err_d = err_q + 8'd1;
            end else begin
              err_d = err_q;
            end
          end else begin
            state_d = ARMED;
          end
        end
        CAPTURE: begin
          state_d = IDLE;
          data_d  = sw_i;
          count_d = count_q + 16'd1;
          load_d  = 1'b1;
        end
        TIMEOUT: begin
          if (arm_ok_s) begin
            state_d = ARMED;
            timer_d = 27'd0;
          end else begin
            state_d = TIMEOUT;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = 27'd0;
        end
      endcase
    end

    timeout_d = (state_d == TIMEOUT);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      timer_q     <= 27'd0;
      key0_prev_q <= 1'b0;
      key2_prev_q <= 1'b0;
      data_q      <= 10'd0;
      count_q     <= 16'd0;
      err_q       <= 8'd0;
      load_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      key0_prev_q <= key0_prev_d;
      key2_prev_q <= key2_prev_d;
      data_q      <= data_d;
      count_q     <= count_d;
      err_q       <= err_d;
      load_q      <= load_d;
      timeout_q   <= timeout_d;
    end
  end

  assign data_o    = data_q;
  assign count_o   = count_q;
  assign err_cnt_o = err_q;
  assign state_o   = state_q;
  assign load_o    = load_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed self-checking bench for capture_sequencer with a 16-cycle armed window.
module tb_capture_sequencer;

  logic        clk100_i;
  logic        rstn_i;
  logic        clr_i;
  logic        key0_pressed_i;
  logic        key2_pressed_i;
  logic [9:0]  sw_i;
  logic [9:0]  data_o;
  logic [15:0] count_o;
  logic [7:0]  err_cnt_o;
  logic [1:0]  state_o;
  logic        load_o;
  logic        timeout_o;

  int n_checks;
  int n_fail;

  capture_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk100_i      (clk100_i),
    .rstn_i        (rstn_i),
    .clr_i         (clr_i),
    .key0_pressed_i(key0_pressed_i),
    .key2_pressed_i(key2_pressed_i),
    .sw_i          (sw_i),
    .data_o        (data_o),
    .count_o       (count_o),
    .err_cnt_o     (err_cnt_o),
    .state_o       (state_o),
    .load_o        (load_o),
    .timeout_o     (timeout_o)
  );

  initial clk100_i = 1'b0;
  always #5 clk100_i = ~clk100_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100_i);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rstn_i         = 1'b0;
    clr_i          = 1'b0;
    key0_pressed_i = 1'b0;
    key2_pressed_i = 1'b0;
    sw_i           = 10'h000;

    #12;
    check("rst_state",   32'(state_o),   32'd0);
    check("rst_data",    32'(data_o),    32'd0);
    check("rst_count",   32'(count_o),   32'd0);
    check("rst_err",     32'(err_cnt_o), 32'd0);
    check("rst_load",    32'(load_o),    32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);

    // key0 held through reset release rises on the first edge.
    key0_pressed_i = 1'b1;
    #1 rstn_i = 1'b1;
    tick();
    check("held_key_arms", 32'(state_o), 32'd1);
    key0_pressed_i = 1'b0;
    tick();
    check("armed_hold", 32'(state_o), 32'd1);

    // Normal capture: two edges from key2 rise to load.
    key2_pressed_i = 1'b1;
    sw_i = 10'h2A5;
    tick();
    check("cap_state",   32'(state_o), 32'd2);
    check("cap_load_lo", 32'(load_o),  32'd0);
    tick();
    check("cap_load",  32'(load_o),  32'd1);
    check("cap_data",  32'(data_o),  32'h2A5);
    check("cap_count", 32'(count_o), 32'd1);
    check("cap_idle",  32'(state_o), 32'd0);
    key2_pressed_i = 1'b0;
    tick();
    check("load_one_cycle", 32'(load_o), 32'd0);

    // Timeout after 16 armed cycles.
    key0_pressed_i = 1'b1;
    tick();
    key0_pressed_i = 1'b0;
    tick_n(15);
    check("to_not_yet", 32'(state_o), 32'd1);
    tick();
    check("to_state",   32'(state_o),   32'd3);
    check("to_flag",    32'(timeout_o), 32'd1);
    check("to_err",     32'(err_cnt_o), 32'd1);
    key0_pressed_i = 1'b1;
    tick();
    check("to_rearm",      32'(state_o),   32'd1);
    check("to_flag_clear", 32'(timeout_o), 32'd0);
    key0_pressed_i = 1'b0;
    tick();

    // Simultaneous press: both rise together, then key2 rises with key0 held.
    key0_pressed_i = 1'b1;
    key2_pressed_i = 1'b1;
    tick();
    check("sim_both_state", 32'(state_o), 32'd1);
    key0_pressed_i = 1'b0;
    key2_pressed_i = 1'b0;
    tick();
    key0_pressed_i = 1'b1;
    tick();
    key2_pressed_i = 1'b1;
    tick();
    check("sim_held_state", 32'(state_o), 32'd1);
    tick();
    check("sim_no_load", 32'(load_o),  32'd0);
    check("sim_count",   32'(count_o), 32'd1);
    key0_pressed_i = 1'b0;
    key2_pressed_i = 1'b0;
    tick();

    // Capture on the timer=15 cycle wins over timeout.
    key0_pressed_i = 1'b1;
    tick();
    key0_pressed_i = 1'b0;
    sw_i = 10'h0F0;
    tick_n(15);
    key2_pressed_i = 1'b1;
    tick();
    check("prio_state", 32'(state_o),   32'd2);
    check("prio_err",   32'(err_cnt_o), 32'd1);
    tick();
    check("prio_load",  32'(load_o),  32'd1);
    check("prio_count", 32'(count_o), 32'd2);
    key2_pressed_i = 1'b0;
    tick();

    // Count wrap from 16'hFFFF.
    force dut.count_q = 16'hFFFF;
    tick();
    release dut.count_q;
    check("wrap_preload", 32'(count_o), 32'hFFFF);
    key0_pressed_i = 1'b1;
    tick();
    key0_pressed_i = 1'b0;
    key2_pressed_i = 1'b1;
    sw_i = 10'h155;
    tick();
    tick();
    check("wrap_count", 32'(count_o), 32'd0);
    check("wrap_data",  32'(data_o),  32'h155);
    check("wrap_load",  32'(load_o),  32'd1);
    key2_pressed_i = 1'b0;
    tick();

    // 256 more timeouts saturate the error counter.
    key0_pressed_i = 1'b1;
    tick();
    key0_pressed_i = 1'b0;
    for (int i = 0; i < 256; i++) begin
      for (int w = 0; w < 20 && state_o != 2'd3; w++) tick();
      check("sat_wait_timeout", 32'(state_o), 32'd3);
      key0_pressed_i = 1'b1;
      tick();
      key0_pressed_i = 1'b0;
    end
    check("sat_err", 32'(err_cnt_o), 32'hFF);

    // Synchronous clear during ARMED.
    check("clr_pre_state", 32'(state_o), 32'd1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check("clr_state", 32'(state_o),   32'd0);
    check("clr_err",   32'(err_cnt_o), 32'd0);
    check("clr_count", 32'(count_o),   32'd0);
    check("clr_data",  32'(data_o),    32'd0);

    // Asynchronous reset in the middle of a CAPTURE cycle.
    key0_pressed_i = 1'b1;
    tick();
    key0_pressed_i = 1'b0;
    key2_pressed_i = 1'b1;
    sw_i = 10'h3FF;
    tick();
    check("ar_in_capture", 32'(state_o), 32'd2);
    #2 rstn_i = 1'b0;
    #1;
    check("ar_state", 32'(state_o),   32'd0);
    check("ar_data",  32'(data_o),    32'd0);
    check("ar_count", 32'(count_o),   32'd0);
    check("ar_load",  32'(load_o),    32'd0);
    check("ar_to",    32'(timeout_o), 32'd0);
    key2_pressed_i = 1'b0;
    tick_n(2);
    rstn_i = 1'b1;
    tick();
    check("ar_after_data",  32'(data_o),  32'd0);
    check("ar_after_count", 32'(count_o), 32'd0);
    check("ar_after_load",  32'(load_o),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
